spart_param: RTL and testbench

Parametrised SPART (UART with a processor-bus register interface) for the mini-project SoC. It has TX and RX FIFOs, a programmable 16-bit baud divisor, a configurable data width, optional parity, and sticky error flags. It sits between the processor I/O bus (iocs/iorw/ioaddr/databus) and the external txd/rxd pins.

---
 rtl/spart_pkg.sv | 25 ++
 rtl/spart_sync_fifo.sv | 48 ++++
 rtl/spart_param.sv | 237 +++++++++++++++++++++++
 tb/tb_spart_param.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART: FSM state encodings,
// bus register addresses and status-byte bit positions.
package spart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    localparam int ST_RDA    = 0;
    localparam int ST_TBR    = 1;
    localparam int ST_TXIDLE = 2;
    localparam int ST_OVR    = 3;
    localparam int ST_FERR   = 4;
    localparam int ST_PERR   = 5;

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO with combinational head output. Pushes when full and
// pops when empty are ignored; a simultaneous push and pop both take effect.
module spart_sync_fifo
    import spart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_push, w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

endmodule

// File: rtl/spart_param.sv
// Parametrised SPART: processor-bus register file, TX/RX FIFOs, baud
// counters and the TX/RX framing FSMs between the bus and txd/rxd.
module spart_param
    import spart_pkg::*;
#(
    parameter int          DATA_BITS   = 8,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          PARITY_EN   = 0,
    parameter int          PARITY_ODD  = 0,
    parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic ODD = (PARITY_ODD != 0);
    localparam logic PEN = (PARITY_EN != 0);

    logic [15:0] r_div, w_div_eff;
    logic        r_perr, r_ferr, r_ovr;
    logic        w_wr, w_rd, w_tx_push, w_rx_pop, w_stat_rd;
    logic [7:0]  w_rdata, w_rx_byte, w_status;

    logic [DATA_BITS-1:0] w_tx_dout, w_rx_dout;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_tx_idle;

    tx_state_t r_tx_state, w_tx_next;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [15:0] r_tx_div, r_tx_cnt;
    logic [BW-1:0] r_tx_bitn;
    logic r_tx_par, w_tx_pop, w_tx_bit_end;

    rx_state_t r_rx_state, w_rx_next;
    logic r_rx_s1, r_rx_s2, r_rx_prev, w_rx_fall;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [15:0] r_rx_div, r_rx_cnt;
    logic [BW-1:0] r_rx_bitn;
    logic r_rx_par, w_rx_load, w_rx_bit_end, w_rx_half_end, w_rx_stop_smp;
    logic w_rx_par_bad, w_rx_push, w_set_ferr, w_set_perr, w_set_ovr;

    assign w_wr      = iocs & ~iorw;
    assign w_rd      = iocs & iorw;
    assign w_tx_push = w_wr & (ioaddr == ADDR_DATA);
    assign w_rx_pop  = w_rd & (ioaddr == ADDR_DATA);
    assign w_stat_rd = w_rd & (ioaddr == ADDR_STATUS);
    assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;

    spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .i_push(w_tx_push), .i_pop(w_tx_pop),
        .i_din(databus[DATA_BITS-1:0]), .o_dout(w_tx_dout),
        .o_full(w_tx_full), .o_empty(w_tx_empty)
    );

    spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .i_push(w_rx_push), .i_pop(w_rx_pop),
        .i_din(r_rx_shift), .o_dout(w_rx_dout),
        .o_full(w_rx_full), .o_empty(w_rx_empty)
    );

    // ---------------- bus side ----------------
    assign w_tx_idle = (r_tx_state == TX_IDLE) & w_tx_empty;
    assign rda = ~w_rx_empty;
    assign tbr = ~w_tx_full;
    assign w_status = {2'b00, r_perr, r_ferr, r_ovr, w_tx_idle, tbr, rda};

    always_comb begin
        w_rx_byte = '0;
        w_rx_byte[DATA_BITS-1:0] = w_rx_dout;
        w_rdata = '0;
        case (ioaddr)
            ADDR_DATA:   if (!w_rx_empty) w_rdata = w_rx_byte;
            ADDR_STATUS: w_rdata = w_status;
            ADDR_DIV_LO: w_rdata = r_div[7:0];
            default:     w_rdata = r_div[15:8];
        endcase
    end

    assign databus = w_rd ? w_rdata : 8'bz;

    // A new error event in the same cycle as a status read keeps its flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= DEFAULT_DIV;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_wr && ioaddr == ADDR_DIV_LO) r_div[7:0]  <= databus;
            if (w_wr && ioaddr == ADDR_DIV_HI) r_div[15:8] <= databus;
            r_perr <= w_set_perr | (r_perr & ~w_stat_rd);
            r_ferr <= w_set_ferr | (r_ferr & ~w_stat_rd);
            r_ovr  <= w_set_ovr  | (r_ovr  & ~w_stat_rd);
        end
    end

    // ---------------- transmitter ----------------
    assign w_tx_bit_end = (r_tx_cnt == r_tx_div);

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            TX_IDLE:   if (!w_tx_empty) begin w_tx_next = TX_START; w_tx_pop = 1'b1; end
            TX_START:  if (w_tx_bit_end) w_tx_next = TX_DATA;
            TX_DATA:   if (w_tx_bit_end && r_tx_bitn == LAST_BIT)
                           w_tx_next = PEN ? TX_PARITY : TX_STOP;
            TX_PARITY: if (w_tx_bit_end) w_tx_next = TX_STOP;
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    if (!w_tx_empty) begin w_tx_next = TX_START; w_tx_pop = 1'b1; end
                    else w_tx_next = TX_IDLE;
                end
            end
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_div   <= 16'd1;
            r_tx_cnt   <= '0;
            r_tx_bitn  <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_dout;
                r_tx_div   <= w_div_eff;
                r_tx_cnt   <= '0;
                r_tx_bitn  <= '0;
                r_tx_par   <= (^w_tx_dout) ^ ODD;
            end else if (r_tx_state != TX_IDLE) begin
                if (w_tx_bit_end) begin
                    r_tx_cnt <= '0;
                    if (r_tx_state == TX_DATA) begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bitn  <= r_tx_bitn + BW'(1);
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 16'd1;
                end
            end
        end
    end

    // Decoded from registers so reset forces the line high without a clock.
    always_comb begin
        case (r_tx_state)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = r_tx_shift[0];
            TX_PARITY: txd = r_tx_par;
            default:   txd = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // Edge-triggered start: a line stuck low after a framing error must go high first.
    assign w_rx_fall     = r_rx_prev & ~r_rx_s2;
    assign w_rx_bit_end  = (r_rx_cnt == r_rx_div);
    assign w_rx_half_end = (r_rx_cnt == ((r_rx_div - 16'd1) >> 1));
    assign w_rx_par_bad  = PEN && (((^r_rx_shift) ^ ODD) != r_rx_par);

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_load     = 1'b0;
        w_rx_stop_smp = 1'b0;
        case (r_rx_state)
            RX_IDLE:   if (w_rx_fall) begin w_rx_next = RX_START; w_rx_load = 1'b1; end
            RX_START:  if (w_rx_half_end) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_rx_bit_end && r_rx_bitn == LAST_BIT)
                           w_rx_next = PEN ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_bit_end) w_rx_next = RX_STOP;
            RX_STOP:   if (w_rx_bit_end) begin w_rx_next = RX_IDLE; w_rx_stop_smp = 1'b1; end
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    assign w_set_ferr = w_rx_stop_smp & ~r_rx_s2;
    assign w_set_perr = w_rx_stop_smp & r_rx_s2 & w_rx_par_bad;
    assign w_rx_push  = w_rx_stop_smp & r_rx_s2 & ~w_rx_par_bad & ~w_rx_full;
    assign w_set_ovr  = w_rx_stop_smp & r_rx_s2 & ~w_rx_par_bad & w_rx_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_shift <= '0;
            r_rx_div   <= 16'd1;
            r_rx_cnt   <= '0;
            r_rx_bitn  <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            if (w_rx_load) begin
                r_rx_div  <= w_div_eff;
                r_rx_cnt  <= '0;
                r_rx_bitn <= '0;
            end else if (r_rx_state == RX_START) begin
                r_rx_cnt <= w_rx_half_end ? 16'd0 : r_rx_cnt + 16'd1;
            end else if (r_rx_state != RX_IDLE) begin
                if (w_rx_bit_end) begin
                    r_rx_cnt <= '0;
                    if (r_rx_state == RX_DATA) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_bitn  <= r_rx_bitn + BW'(1);
                    end
                    if (r_rx_state == RX_PARITY) r_rx_par <= r_rx_s2;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spart_param.sv
// Randomised scoreboard bench for spart_param: unit 0 is the default build,
// unit 1 has even parity enabled. Bus reads and txd frames are checked by monitors.
module tb_spart_param;
    localparam logic [1:0] A_DATA = 2'b00, A_STAT = 2'b01, A_DLO = 2'b10, A_DHI = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic       cs [2];
    logic       rw [2];
    logic [1:0] ad [2];
    logic [7:0] wd [2];
    logic       rxd_i [2];
    wire  [7:0] db0, db1;
    wire        rda0, tbr0, txd0, rda1, tbr1, txd1;

    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign db0 = (cs[0] && !rw[0]) ? wd[0] : 8'bz;
    assign db1 = (cs[1] && !rw[1]) ? wd[1] : 8'bz;

    spart_param u0 (
        .clk(clk), .rst(rst), .iocs(cs[0]), .iorw(rw[0]), .ioaddr(ad[0]),
        .databus(db0), .rda(rda0), .tbr(tbr0), .txd(txd0), .rxd(rxd_i[0])
    );

    spart_param #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .iocs(cs[1]), .iorw(rw[1]), .ioaddr(ad[1]),
        .databus(db1), .rda(rda1), .tbr(tbr1), .txd(txd1), .rxd(rxd_i[1])
    );

    // ---------------- reference model ----------------
    typedef struct packed { logic u; logic [1:0] a; logic [7:0] e; } rd_t;
    rd_t        rdq[$];
    logic [7:0] txq[$];
    int         tx_starts[$];
    int         tx_period = 326;
    logic [7:0] rxm0[$], rxm1[$];
    logic       m_perr [2], m_ferr [2], m_ovr [2];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status(input int u);
        logic nonempty;
        nonempty = (u == 0) ? (rxm0.size() != 0) : (rxm1.size() != 0);
        return {2'b00, m_perr[u], m_ferr[u], m_ovr[u], 1'b1, 1'b1, nonempty};
    endfunction

    // ---------------- bus tasks (called at posedge+1) ----------------
    task automatic wr(input int u, input logic [1:0] a, input logic [7:0] d);
        cs[u] = 1'b1; rw[u] = 1'b0; ad[u] = a; wd[u] = d;
        @(posedge clk); #1;
        cs[u] = 1'b0;
    endtask

    task automatic rd(input int u, input logic [1:0] a, input logic [7:0] e);
        rdq.push_back({u[0], a, e});
        cs[u] = 1'b1; rw[u] = 1'b1; ad[u] = a;
        @(posedge clk); #1;
        cs[u] = 1'b0; rw[u] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_status(input int u);
        rd(u, A_STAT, exp_status(u));
        m_perr[u] = 1'b0; m_ferr[u] = 1'b0; m_ovr[u] = 1'b0;
    endtask

    task automatic rd_data(input int u);
        logic [7:0] e;
        e = 8'h00;
        if (u == 0 && rxm0.size() != 0) e = rxm0.pop_front();
        if (u == 1 && rxm1.size() != 0) e = rxm1.pop_front();
        rd(u, A_DATA, e);
    endtask

    // Drives one serial frame (bit period P) and applies the spec's frame rules to the model.
    task automatic send_frame(input int u, input logic [7:0] d, input logic pbit, input logic sbit);
        int P;
        logic par_ok;
        P = 10;
        rxd_i[u] = 1'b0; idle(P);
        for (int i = 0; i < 8; i++) begin rxd_i[u] = d[i]; idle(P); end
        if (u == 1) begin rxd_i[u] = pbit; idle(P); end
        rxd_i[u] = sbit; idle(P);
        rxd_i[u] = 1'b1; idle(P);
        par_ok = (u == 0) || (pbit == ($countones(d) % 2 == 1));
        if (!sbit) m_ferr[u] = 1'b1;
        else if (!par_ok) m_perr[u] = 1'b1;
        else if (u == 0) begin
            if (rxm0.size() == 4) m_ovr[0] = 1'b1; else rxm0.push_back(d);
        end else begin
            if (rxm1.size() == 4) m_ovr[1] = 1'b1; else rxm1.push_back(d);
        end
    endtask

    // ---------------- read monitor ----------------
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (cs[u] === 1'b1 && rw[u] === 1'b1) begin
                logic [7:0] got;
                rd_t ent;
                got = (u == 0) ? db0 : db1;
                checks++;
                if (rdq.size() == 0) begin
                    errors++;
                    $display("FAIL read u%0d: unexpected read, got %h expected nothing", u, got);
                end else begin
                    ent = rdq.pop_front();
                    if (got !== ent.e || ent.u != u[0]) begin
                        errors++;
                        $display("FAIL read u%0d addr %0d: got %h expected %h", u, ent.a, got, ent.e);
                    end
                end
            end
        end
    end

    // ---------------- txd monitor (unit 0) ----------------
    logic tx_prev = 1'b1;
    always begin
        @(negedge clk);
        if (tx_prev && txd0 === 1'b0) begin
            int p, n;
            logic ok;
            logic [7:0] e, got;
            logic [9:0] fb;
            p = tx_period; n = 10 * p; ok = 1'b1; got = '0;
            tx_starts.push_back(cyc);
            if (txq.size() == 0) begin e = 8'h00; ok = 1'b0; end
            else e = txq.pop_front();
            fb = {1'b1, e, 1'b0};
            for (int i = 0; i < n; i++) begin
                if (i > 0) @(negedge clk);
                if (txd0 !== fb[i / p]) ok = 1'b0;
                if (i / p >= 1 && i / p <= 8 && i % p == p / 2) got[i / p - 1] = txd0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL txd frame: got %h expected %h (period %0d)", got, e, p);
            end
            tx_prev = txd0;
        end else begin
            tx_prev = txd0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        for (int u = 0; u < 2; u++) begin
            cs[u] = 1'b0; rw[u] = 1'b0; ad[u] = 2'b00; wd[u] = 8'h00; rxd_i[u] = 1'b1;
            m_perr[u] = 1'b0; m_ferr[u] = 1'b0; m_ovr[u] = 1'b0;
        end
        idle(3);
        rst = 1'b1;
        idle(2);

        // reset state
        chk("rst rda", rda0, 0);
        chk("rst tbr", tbr0, 1);
        chk("rst txd", txd0, 1);
        rd(0, A_STAT, 8'h06);
        rd(0, A_DLO, 8'h45);
        rd(0, A_DHI, 8'h01);
        rd(1, A_STAT, 8'h06);

        // single frame at divisor 9
        wr(0, A_DLO, 8'h09); wr(0, A_DHI, 8'h00);
        rd(0, A_DLO, 8'h09);
        tx_period = 10;
        txq.push_back(8'h55);
        wr(0, A_DATA, 8'h55);
        idle(50);
        rd(0, A_STAT, 8'h02);
        idle(60);
        rd(0, A_STAT, 8'h06);

        // divisor 0 behaves as 1: two-cycle bits
        wr(0, A_DLO, 8'h00);
        tx_period = 2;
        b = 8'($urandom);
        txq.push_back(b);
        wr(0, A_DATA, b);
        idle(30);
        wr(0, A_DLO, 8'h09);
        tx_period = 10;

        // random single frames
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            txq.push_back(b);
            wr(0, A_DATA, b);
            idle(105);
        end

        // burst fills the FIFO behind a frame in flight; the extra write is dropped
        tx_starts.delete();
        for (int i = 0; i < 5; i++) txq.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 5; i++) wr(0, A_DATA, 8'h10 + 8'(i));
        chk("burst tbr full", tbr0, 0);
        wr(0, A_DATA, 8'h99);
        chk("burst tbr still full", tbr0, 0);
        idle(520);
        chk("burst frame count", 16'(tx_starts.size()), 5);
        for (int i = 1; i < tx_starts.size(); i++)
            chk("burst frame spacing", 16'(tx_starts[i] - tx_starts[i-1]), 100);
        chk("tx queue drained", 16'(txq.size()), 0);
        rd(0, A_STAT, 8'h06);

        // receive overrun
        for (int i = 0; i < 5; i++) send_frame(0, 8'hA1 + 8'(i), 1'b0, 1'b1);
        chk("ovr rda", rda0, 1);
        for (int i = 0; i < 5; i++) rd_data(0);
        chk("ovr drained rda", rda0, 0);
        rd_status(0);
        rd_status(0);

        // false start: 3-cycle low pulse
        rxd_i[0] = 1'b0; idle(3); rxd_i[0] = 1'b1; idle(30);
        chk("false start rda", rda0, 0);
        rd_status(0);

        // framing error
        send_frame(0, 8'h5A, 1'b0, 1'b0);
        chk("ferr rda", rda0, 0);
        rd_status(0);
        rd_status(0);

        // random frames with occasional framing errors and interleaved reads
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            send_frame(0, b, 1'b0, ($urandom_range(3) != 0));
            if ($urandom_range(2) == 0) rd_data(0);
            if ($urandom_range(3) == 0) rd_status(0);
        end
        while (rxm0.size() != 0) rd_data(0);
        rd_status(0);

        // parity unit
        wr(1, A_DLO, 8'h09); wr(1, A_DHI, 8'h00);
        send_frame(1, 8'h03, 1'b1, 1'b1);
        chk("perr rda", rda1, 0);
        rd_status(1);
        send_frame(1, 8'h03, 1'b0, 1'b1);
        chk("parity good rda", rda1, 1);
        rd_data(1);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_frame(1, b, (^b) ^ ($urandom_range(1) == 0), 1'b1);
            rd_status(1);
            rd_data(1);
        end

        // reset in the middle of a frame forces txd high without a clock edge
        wr(1, A_DATA, 8'h00);
        idle(5);
        chk("midframe txd low", txd1, 0);
        #2 rst = 1'b0;
        #1 chk("async reset txd", txd1, 1);
        idle(2);
        rst = 1'b1;
        idle(1);
        for (int u = 0; u < 2; u++) begin m_perr[u] = 0; m_ferr[u] = 0; m_ovr[u] = 0; end
        rxm1.delete();
        rd_status(1);
        rd(1, A_DLO, 8'h45);
        idle(2);

        chk("read queue drained", 16'(rdq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
